// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART byte receiver with held output byte and frame-error flag
module uart_byte_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_done,
    output logic       uart_busy,
    output logic       frame_err
);

    localparam int          BPS_CNT = CLK_FREQ / BAUD;
    localparam logic [15:0] CNT_MAX = 16'(BPS_CNT - 1);
    localparam logic [15:0] CNT_MID = 16'(BPS_CNT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
        BRK_WAIT = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        rxd_s1;
    logic        rxd_s2;
    logic        rxd_s3;
    logic [15:0] clk_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift_reg;

    logic        start_edge;
    logic        sample_pt;
    logic        cnt_wrap;
    logic        cnt_run;
    logic        shift_en;
    logic        load_en;
    logic        err_en;

    assign sample_pt  = (clk_cnt == CNT_MID);
    assign cnt_wrap   = (clk_cnt == CNT_MAX);
    assign start_edge = (state == IDLE) && rxd_s3 && !rxd_s2;

    // Two-stage synchroniser for the async line, third stage for falling-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_s3 <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; leaving STOP happens at the stop-bit midpoint so back-to-back frames resync
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_edge) state_next = START;
            end
            START: begin
                if (sample_pt && rxd_s2) state_next = IDLE;
                else if (cnt_wrap)       state_next = DATA;
            end
            DATA: begin
                if (cnt_wrap && bit_cnt == 4'd7) state_next = STOP;
            end
            STOP: begin
                if (sample_pt) state_next = rxd_s2 ? IDLE : BRK_WAIT;
            end
            BRK_WAIT: begin
                if (rxd_s2) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output and datapath-enable decode from the current state
    always_comb begin
        cnt_run   = 1'b0;
        shift_en  = 1'b0;
        load_en   = 1'b0;
        err_en    = 1'b0;
        uart_busy = 1'b0;
        case (state)
            START: begin
                cnt_run   = (state_next == START) || (state_next == DATA);
                uart_busy = 1'b1;
            end
            DATA: begin
                cnt_run   = 1'b1;
                shift_en  = sample_pt;
                uart_busy = 1'b1;
            end
            STOP: begin
                cnt_run   = !sample_pt;
                load_en   = sample_pt && rxd_s2;
                err_en    = sample_pt && !rxd_s2;
                uart_busy = 1'b1;
            end
            default: begin
                cnt_run   = 1'b0;
            end
        endcase
    end

    // Per-bit clock counter; held at zero whenever no frame slot is being timed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt <= 16'd0;
        end else if (!cnt_run || cnt_wrap) begin
            clk_cnt <= 16'd0;
        end else begin
            clk_cnt <= clk_cnt + 16'd1;
        end
    end

    // Data-bit slot counter, advanced on each slot wrap while in DATA
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 4'd0;
        end else if (state != DATA) begin
            bit_cnt <= 4'd0;
        end else if (cnt_wrap) begin
            bit_cnt <= bit_cnt + 4'd1;
        end
    end

    // Right-shift deserialiser, LSB arrives first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= 8'h00;
        end else if (shift_en) begin
            shift_reg <= {rxd_s2, shift_reg[7:1]};
        end
    end

    // Registered outputs; uart_data only moves on a good stop bit so downstream decode stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uart_data <= 8'h00;
            uart_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            uart_done <= load_en;
            frame_err <= err_en;
            if (load_en) uart_data <= shift_reg;
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - scoreboard bench for uart_byte_rx
module tb_uart_byte_rx;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115200;
    localparam int BPS      = CLK_FREQ / BAUD;
    localparam int LATENCY  = 9 * BPS + BPS / 2 + 3;
    localparam int GLITCH   = BPS / 3;
    localparam int BPS_FAST = 426;
    localparam int BPS_SLOW = 443;

    logic       clk;
    logic       rst_n;
    logic       uart_rxd;
    logic [7:0] uart_data;
    logic       uart_done;
    logic       uart_busy;
    logic       frame_err;

    typedef struct {
        logic [7:0] data;
        bit         is_err;
        int         t0;
        bit         chk_lat;
    } exp_t;

    exp_t       exp_q[$];
    int         checks;
    int         errors;
    int         cyc;
    logic [7:0] last_good;

    uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rxd  (uart_rxd),
        .uart_data (uart_data),
        .uart_done (uart_done),
        .uart_busy (uart_busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic chk_range(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Monitor: every done / frame_err pulse is matched against the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && (uart_done || frame_err)) begin
            exp_t e;
            chk("done_err_exclusive", int'(uart_done && frame_err), 0);
            chk("busy_low_at_pulse", int'(uart_busy), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", int'(uart_done) * 2 + int'(frame_err), 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind_err", int'(frame_err), int'(e.is_err));
                chk("uart_data", int'(uart_data), int'(e.data));
                if (e.chk_lat) chk_range("latency", cyc - e.t0, LATENCY - 1, LATENCY + 1);
            end
        end
    end

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; caller is aligned 1ns after a rising edge and stays so on return
    task automatic send(input logic [7:0] b, input int nclk, input bit stop_val, input bit chk_lat);
        exp_t e;
        e.t0      = cyc;
        e.chk_lat = chk_lat;
        e.is_err  = !stop_val;
        e.data    = stop_val ? b : last_good;
        if (stop_val) last_good = b;
        exp_q.push_back(e);
        uart_rxd = 1'b0;
        repeat (nclk) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (nclk) @(posedge clk);
            #1;
        end
        uart_rxd = stop_val;
        repeat (nclk) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int g;
        int n;
        int bad;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        last_good = 8'h00;
        rst_n     = 1'b0;
        uart_rxd  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_data", int'(uart_data), 8'h00);
        chk("reset_done", int'(uart_done), 0);
        chk("reset_busy", int'(uart_busy), 0);
        chk("reset_ferr", int'(frame_err), 0);
        rst_n = 1'b1;
        idle(20);

        // Single frame, then hold check
        send(8'h45, BPS, 1'b1, 1'b1);
        drain("drain_45");
        bad = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (uart_data != 8'h45) bad++;
        end
        chk("hold_45_mismatches", bad, 0);
        @(posedge clk);
        #1;

        // Back-to-back frames, one stop bit, no gap
        send(8'h41, BPS, 1'b1, 1'b1);
        send(8'hC3, BPS, 1'b1, 1'b1);
        drain("drain_41_c3");
        idle(BPS);

        // Short low glitch on an idle line
        g = cyc;
        uart_rxd = 1'b0;
        repeat (GLITCH) @(posedge clk);
        #1;
        uart_rxd = 1'b1;
        n = 0;
        while (uart_busy && n < 4 * BPS) begin
            @(negedge clk);
            n++;
        end
        chk_range("glitch_busy_fall", cyc - g, BPS / 2 + 1, BPS / 2 + 3);
        @(posedge clk);
        #1;
        idle(BPS);
        send(8'h5A, BPS, 1'b1, 1'b1);
        drain("drain_5a");

        // Stop bit low followed by a held break
        send(8'h81, BPS, 1'b0, 1'b1);
        uart_rxd = 1'b0;
        repeat (5000) @(posedge clk);
        #1;
        drain("drain_81_ferr");
        chk("data_after_ferr", int'(uart_data), 8'h5A);
        idle(2 * BPS);
        send(8'h0F, BPS, 1'b1, 1'b1);
        drain("drain_0f");

        // Reset in the middle of the fourth data bit of 8'hFF
        uart_rxd = 1'b0;
        repeat (BPS) @(posedge clk);
        #1;
        uart_rxd = 1'b1;
        repeat (3 * BPS + BPS / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("midreset_data", int'(uart_data), 8'h00);
        chk("midreset_done", int'(uart_done), 0);
        chk("midreset_busy", int'(uart_busy), 0);
        chk("midreset_ferr", int'(frame_err), 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        last_good = 8'h00;
        idle(6 * BPS);
        send(8'h22, BPS, 1'b1, 1'b1);
        drain("drain_22");
        idle(BPS);

        // Baud mismatch, +2% then -2%
        send(8'h96, BPS_FAST, 1'b1, 1'b0);
        drain("drain_96_fast");
        idle(2 * BPS);
        send(8'h96, BPS_SLOW, 1'b1, 1'b0);
        drain("drain_96_slow");
        idle(2 * BPS);
        chk("final_data", int'(uart_data), 8'h96);
        chk("final_busy", int'(uart_busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
